// File: rtl/if_id_buffer.sv
// ---------------------------------------------------------------------------
// if_id_buffer
//
// Purpose:
//   Two-entry circular buffer that decouples instruction fetch from decode.
//   Fetch pushes {pc, instr} pairs. Decode consumes the head entry unless it
//   stalls. A flush discards everything that is buffered, together with the
//   instruction arriving in the same cycle. When the buffer is empty it
//   presents a nop (all-zero pc/instr), so decode never sees stale data.
//
// Optional feature (macro IF_ID_EXC_EN):
//   When defined, each entry carries a 5-bit exception code, exposed on
//   exc_out. A fetch from a misaligned PC, or from a PC outside the text
//   window 0x3000..0x6FFC, is tagged AdEL (5'd4). Its instruction word is
//   replaced by 0. Without the macro there is no exc_out port and
//   instructions are stored unmodified.
//
// Ports:
//   clk        in   1   clock, all state updates on posedge
//   reset      in   1   asynchronous, active-low reset
//   in_pc      in   32  PC of the fetched instruction
//   in_instr   in   32  fetched instruction word
//   in_valid   in   1   fetch slot holds a real instruction
//   in_ready   out  1   buffer accepts a push this cycle (registered state only)
//   id_stall   in   1   decode holds; head is not consumed
//   flush      in   1   discard buffered and incoming instructions
//   out_pc     out  32  PC of head entry (0 when empty)
//   out_instr  out  32  instruction of head entry (0 when empty)
//   out_valid  out  1   head entry present
//   count      out  2   occupancy 0..2
//   exc_out    out  5   head exception code (only with IF_ID_EXC_EN)
//
// Parameter:
//   DEPTH      number of entries; only 2 is supported (1-bit wrapping pointers)
// ---------------------------------------------------------------------------
module if_id_buffer #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_instr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        id_stall,
  input  logic        flush,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_valid,
  output logic [1:0]  count
`ifdef IF_ID_EXC_EN
  ,
  output logic [4:0]  exc_out
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef IF_ID_EXC_EN
  localparam logic [31:0] TEXT_LO  = 32'h0000_3000;
  localparam logic [31:0] TEXT_HI  = 32'h0000_6FFC;
  localparam logic [4:0]  EXC_ADEL = 5'd4;

  // Instruction-fetch address error: misaligned, or outside the text window.
  function automatic logic fetch_addr_fault(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || (pc < TEXT_LO) || (pc > TEXT_HI);
  endfunction
`endif

  // Storage and control state
  logic [31:0]      pc_q    [DEPTH];
  logic [31:0]      pc_d    [DEPTH];
  logic [31:0]      instr_q [DEPTH];
  logic [31:0]      instr_d [DEPTH];
`ifdef IF_ID_EXC_EN
  logic [4:0]       exc_q   [DEPTH];
  logic [4:0]       exc_d   [DEPTH];
  logic             fault;
`endif
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [1:0]       count_q, count_d;

  logic             push;
  logic             pop;

  // in_ready depends only on registered occupancy. A full buffer therefore
  // refuses a push even in a cycle where decode pops the head; the freed
  // slot becomes visible on the next cycle.
  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign count     = count_q;

  // Flush masks both handshakes, so it always wins over push and pop.
  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && !id_stall && !flush;

`ifdef IF_ID_EXC_EN
  assign fault = fetch_addr_fault(in_pc);
`endif

  // Next-state logic
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
`ifdef IF_ID_EXC_EN
    exc_d   = exc_q;
`endif
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;

    if (flush) begin
      // Storage is left as is; zeroing the pointers and count makes the
      // old contents unreachable.
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = 2'd0;
    end else begin
      if (push) begin
        pc_d[wptr_q] = in_pc;
`ifdef IF_ID_EXC_EN
        instr_d[wptr_q] = fault ? 32'h0 : in_instr;
        exc_d[wptr_q]   = fault ? EXC_ADEL : 5'd0;
`else
        instr_d[wptr_q] = in_instr;
`endif
        wptr_d = wptr_q + 1'b1;
      end

      if (pop) begin
        rptr_d = rptr_q + 1'b1;
      end

      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
`ifdef IF_ID_EXC_EN
        exc_q[i]   <= '0;
`endif
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= 2'd0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= pc_d[i];
        instr_q[i] <= instr_d[i];
`ifdef IF_ID_EXC_EN
        exc_q[i]   <= exc_d[i];
`endif
      end
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Head presentation: an empty buffer shows a nop rather than stale data.
  always_comb begin
    out_pc    = 32'h0;
    out_instr = 32'h0;
`ifdef IF_ID_EXC_EN
    exc_out   = 5'd0;
`endif
    if (out_valid) begin
      out_pc    = pc_q[rptr_q];
      out_instr = instr_q[rptr_q];
`ifdef IF_ID_EXC_EN
      exc_out   = exc_q[rptr_q];
`endif
    end
  end

endmodule

// File: tb/tb_if_id_buffer.sv
// ---------------------------------------------------------------------------
// tb_if_id_buffer
//
// Directed and short random stimulus for if_id_buffer. A queue holds the
// entries expected to be in the buffer. Each accepted push appends to it,
// each pop removes its front, and a flush or reset empties it. Before every
// clock edge, the DUT head, count, in_ready and out_valid are compared with
// the queue. Define IF_ID_EXC_EN for both files to exercise exc_out.
// ---------------------------------------------------------------------------
module tb_if_id_buffer;

  logic        clk;
  logic        reset;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        in_valid;
  logic        in_ready;
  logic        id_stall;
  logic        flush;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_valid;
  logic [1:0]  count;
`ifdef IF_ID_EXC_EN
  logic [4:0]  exc_out;
`endif

  int checks;
  int errors;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  exc;
  } ent_t;

  ent_t sb[$];

  if_id_buffer #(.DEPTH(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .id_stall  (id_stall),
    .flush     (flush),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .out_valid (out_valid),
    .count     (count)
`ifdef IF_ID_EXC_EN
    ,
    .exc_out   (exc_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Expected stored form of a fetched instruction.
  function automatic ent_t mk(input logic [31:0] pc, input logic [31:0] instr);
    ent_t e;
    e.pc    = pc;
    e.instr = instr;
    e.exc   = 5'd0;
`ifdef IF_ID_EXC_EN
    if (pc[1:0] != 2'b00 || pc < 32'h3000 || pc > 32'h6FFC) begin
      e.instr = 32'h0;
      e.exc   = 5'd4;
    end
`endif
    return e;
  endfunction

  task automatic check_outputs(input string step);
    ent_t h;
    h = (sb.size() != 0) ? sb[0] : '0;
    chk({step, ".out_valid"}, 32'(out_valid), 32'(sb.size() != 0));
    chk({step, ".count"},     32'(count),     32'(sb.size()));
    chk({step, ".in_ready"},  32'(in_ready),  32'(sb.size() != 2));
    chk({step, ".out_pc"},    out_pc,         h.pc);
    chk({step, ".out_instr"}, out_instr,      h.instr);
`ifdef IF_ID_EXC_EN
    chk({step, ".exc_out"},   32'(exc_out),   32'(h.exc));
`endif
  endtask

  // One clock cycle: drive inputs, compare the current head, update the model,
  // and advance to just after the edge.
  task automatic cyc(input string step, input logic [31:0] pc, input logic [31:0] instr,
                     input logic v, input logic st, input logic fl);
    bit do_push;
    bit do_pop;
    in_pc    = pc;
    in_instr = instr;
    in_valid = v;
    id_stall = st;
    flush    = fl;
    #1;
    check_outputs(step);
    if (fl) begin
      sb.delete();
    end else begin
      do_push = v && (sb.size() != 2);
      do_pop  = (sb.size() != 0) && !st;
      if (do_pop)  void'(sb.pop_front());
      if (do_push) sb.push_back(mk(pc, instr));
    end
    @(posedge clk);
    #1;
  endtask

  logic [31:0] pc_tbl [8];

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b0;
    in_pc    = '0;
    in_instr = '0;
    in_valid = 1'b0;
    id_stall = 1'b0;
    flush    = 1'b0;
    pc_tbl[0] = 32'h0000_3000; pc_tbl[1] = 32'h0000_6FFC;
    pc_tbl[2] = 32'h0000_2FFC; pc_tbl[3] = 32'h0000_7000;
    pc_tbl[4] = 32'h0000_3001; pc_tbl[5] = 32'h0000_4A10;
    pc_tbl[6] = 32'h0000_3402; pc_tbl[7] = 32'h0000_5554;

    // Reset state, before any clock edge
    #3;
    check_outputs("por");
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Two pushes with decode stalled: fills the buffer, head held
    cyc("fill0", 32'h3000, 32'h2401_0001, 1'b1, 1'b1, 1'b0);
    cyc("fill1", 32'h3004, 32'h2402_0002, 1'b1, 1'b1, 1'b0);
    cyc("full_hold", 32'h3008, 32'h2403_0003, 1'b1, 1'b1, 1'b0);
    chk("full.count", 32'(count), 32'd2);
    chk("full.in_ready", 32'(in_ready), 32'd0);
    chk("full.out_pc", out_pc, 32'h3000);

    // Drain with fetch still offering: full-buffer pop refuses the push
    cyc("drain0", 32'h3008, 32'h2403_0003, 1'b1, 1'b0, 1'b0);
    cyc("drain1", 32'h3008, 32'h2403_0003, 1'b1, 1'b0, 1'b0);
    // count=1, simultaneous push and pop: head becomes the new entry
    cyc("pushpop", 32'h300C, 32'h2404_0004, 1'b1, 1'b0, 1'b0);
    chk("pushpop.count", 32'(count), 32'd1);
    chk("pushpop.out_pc", out_pc, 32'h300C);
    cyc("refill", 32'h3010, 32'h2405_0005, 1'b1, 1'b1, 1'b0);

    // Flush while full with an incoming instruction
    cyc("flush", 32'h5000, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1);
    chk("flush.count", 32'(count), 32'd0);
    chk("flush.out_instr", out_instr, 32'h0);
    cyc("post_flush", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("post_flush.out_pc", out_pc, 32'h0);

    // Fill again, then assert reset between edges
    cyc("rfill0", 32'h3100, 32'h1111_1111, 1'b1, 1'b1, 1'b0);
    cyc("rfill1", 32'h3104, 32'h2222_2222, 1'b1, 1'b1, 1'b0);
    chk("rfill.count", 32'(count), 32'd2);
    #2;
    reset = 1'b0;
    #1;
    sb.delete();
    chk("async_rst.out_valid", 32'(out_valid), 32'd0);
    chk("async_rst.count", 32'(count), 32'd0);
    chk("async_rst.in_ready", 32'(in_ready), 32'd1);
    check_outputs("async_rst");
    // Push attempted while reset is held is discarded
    in_pc    = 32'h4444;
    in_instr = 32'h4444_4444;
    in_valid = 1'b1;
    id_stall = 1'b0;
    @(posedge clk);
    #1;
    check_outputs("rst_held");
    reset = 1'b1;

    // Resume after reset; address-check cases back to back
    cyc("exc0", 32'h3002, 32'h1234_5678, 1'b1, 1'b0, 1'b0);
    cyc("exc1", 32'h7000, 32'h2345_6789, 1'b1, 1'b0, 1'b0);
    cyc("exc2", 32'h3008, 32'h3456_789A, 1'b1, 1'b0, 1'b0);
    cyc("exc3", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    cyc("exc4", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Random traffic including boundary PCs
    for (int i = 0; i < 80; i++) begin
      cyc("rand", pc_tbl[$urandom_range(0, 7)], $urandom,
          ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 15) == 0));
    end
    cyc("final", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_id_buffer.md
IF_ID_BUFFER -- requirements
Module: if_id_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of buffer entries; only the value 2 is supported.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have port in_pc  input  32  PC of the fetched instruction, from the PC register.
REQ-005 SHALL have port in_instr  input  32  fetched instruction word from instruction memory.
REQ-006 SHALL have port in_valid  input  1  fetch slot holds a real instruction.
REQ-007 SHALL have port in_ready  output  1  buffer accepts a push this cycle; the PC stall input is driven from its inverse.
REQ-008 SHALL have port id_stall  input  1  decode holds; the head is not consumed.
REQ-009 SHALL have port flush  input  1  discard all buffered and incoming instructions.
REQ-010 SHALL have port out_pc  output  32  PC of the head entry.
REQ-011 SHALL have port out_instr  output  32  instruction of the head entry.
REQ-012 SHALL have port out_valid  output  1  head entry present.
REQ-013 SHALL have port count  output  2  occupancy, 0..2.

Function
REQ-014 SHALL store entries in a 2-deep circular buffer with 1-bit wptr and 1-bit rptr, both wrapping 1->0.
REQ-015 SHALL drive in_ready = (count != 2); it depends only on registered state, with no combinational path from id_stall or flush.
REQ-016 SHALL push in_pc/in_instr at wptr and advance wptr when in_valid && in_ready && !flush.
REQ-017 SHALL pop (advance rptr) when out_valid && !id_stall && !flush.
REQ-018 SHALL update count as follows: push only: +1; pop only: -1; push and pop together: unchanged.
REQ-019 SHALL drive out_valid = (count != 0).
REQ-020 SHALL drive out_pc/out_instr from entry[rptr] when out_valid=1, else 32'h0 for both (the bubble is a nop).
REQ-021 SHALL, on flush, set count=0 and wptr=rptr=0 at the next edge; flush has priority over push and pop, and the incoming instruction is dropped.
REQ-022 SHALL, when count=2 and a pop occurs, not accept a push in that same cycle (in_ready=0); the next cycle has count=1.
REQ-023 SHALL, when count=0, accept a push and present it at out_* on the following cycle (1-cycle latency); there is no bypass.
REQ-024 SHALL leave storage contents unchanged when neither push nor pop occurs.

Reset
REQ-025 SHALL, while reset=0, asynchronously clear count, wptr, rptr and all entry pc/instr fields to 0, giving out_valid=0, out_pc=0, out_instr=0, in_ready=1.
REQ-026 SHALL treat reset mid-operation as discarding all entries, including any push in flight on that edge.
REQ-027 SHALL resume normal operation on the first posedge after reset deasserts.

Configuration
REQ-028 SHALL, when macro IF_ID_EXC_EN is defined, add port exc_out (output, 5 bits) and a 5-bit exc field per entry.
REQ-029 SHALL, with IF_ID_EXC_EN, on push set exc=5'd4 (AdEL) when in_pc[1:0]!=0 or in_pc is outside 32'h00003000..32'h00006FFC, and store instr as 32'h0; otherwise exc=0.
REQ-030 SHALL, with IF_ID_EXC_EN, drive exc_out from entry[rptr] when out_valid=1, else 0; exc fields are cleared by reset.
REQ-031 SHALL, without IF_ID_EXC_EN, have no exc_out port and store instructions unmodified.

Verification
REQ-032 SHALL cover: reset low mid-stream with count=2 -> out_valid=0, count=0, in_ready=1 immediately, without waiting for a clock edge.
REQ-033 SHALL cover: push pc=0x3000/instr=0x24010001, then 0x3004/0x24020002 with id_stall=1 -> count=2, in_ready=0, out_pc=0x3000 held.
REQ-034 SHALL cover: from count=2, id_stall=0 for 2 cycles with in_valid=1 -> pop 0x3000 then 0x3004; the pushes resume in order with no loss or duplication.
REQ-035 SHALL cover: count=1 with push and pop on the same edge -> count stays 1; head becomes the newly pushed entry.
REQ-036 SHALL cover: flush=1 with count=2 and in_valid=1 -> next cycle count=0, out_instr=0, and the incoming PC is never output.
REQ-037 SHALL cover, with IF_ID_EXC_EN: push in_pc=0x3002 -> exc_out=4 and out_instr=0; push in_pc=0x7000 -> exc_out=4; push in_pc=0x3008 -> exc_out=0.
